// File: rtl/nand4_bist_if.sv
// Purpose: bundles the BIST control/status and NAND-stage connections.
// Signals:
//   start    - one-cycle run request (master -> BIST)
//   y_in     - NAND output under test (master -> BIST)
//   a_out    - pattern driven onto the NAND inputs (BIST -> master)
//   busy     - run in progress
//   done     - one-cycle pulse after the last compare
//   pass     - last run saw zero mismatches
//   err_cnt  - saturating mismatch count
//   fail_vec - first failing pattern (zero unless fail logging is built in)
interface nand4_bist_if;
    logic       start;
    logic       y_in;
    logic [3:0] a_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_vec;

    modport master (
        output start, y_in,
        input  a_out, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, y_in,
        output a_out, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/nand4_bist.sv
// Purpose: self-test sequencer for a 4-input NAND stage. Sweeps all 16 input
//          patterns PASSES times, holds each for HOLD cycles, compares the
//          sampled output with ~&a and reports a saturating mismatch count.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - nand4_bist_if.slave (start, y_in, a_out, busy, done, pass,
//         err_cnt, fail_vec)
// Build option: define NAND4_BIST_FAILLOG_EN to capture the first failing
//               pattern of a run on fail_vec; otherwise fail_vec reads 0.
module nand4_bist #(
    parameter int unsigned HOLD   = 20,
    parameter int unsigned PASSES = 2
) (
    input  logic         clk,
    input  logic         rst,
    nand4_bist_if.slave  bus
);

    localparam int unsigned NVEC   = 16 * PASSES;
    localparam int unsigned VEC_W  = $clog2(NVEC);
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned ERR_W  = 8;

    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NVEC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         a_q, a_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [3:0]         fv_q, fv_d;
    logic               sample_c;
    logic               mismatch_c;

    // Compare happens on the last hold cycle of each pattern.
    assign sample_c   = (hold_q == HOLD_LAST);
    assign mismatch_c = sample_c && (bus.y_in != ~&a_q);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fv_d    = fv_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_DRIVE;
                    a_d     = 4'd0;
                    hold_d  = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    fv_d    = 4'd0;
                end
            end
            S_DRIVE: begin
                hold_d = hold_q + HOLD_W'(1);
                if (sample_c) begin
                    if (mismatch_c) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        // err_q==0 marks the first mismatch; the count never wraps back to 0.
                        if (err_q == '0) begin
                            fv_d = a_q;
                        end
                    end
                    a_d    = a_q + 4'd1;
                    hold_d = '0;
                    vec_d  = vec_q + VEC_W'(1);
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        a_d     = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 4'd0;
            hold_q  <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef NAND4_BIST_FAILLOG_EN
    // First-failure capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q <= 4'd0;
        end else begin
            fv_q <= fv_d;
        end
    end
    assign bus.fail_vec = fv_q;
`else
    assign fv_q         = 4'd0;
    assign bus.fail_vec = 4'd0;
`endif

    assign bus.a_out   = a_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;

endmodule
